// File: rtl/clk_period_monitor_if.sv
// Monitor-side signals of clk_period_monitor: observed clock and enable in, edge pulses and measurements out.
// Purely combinational wiring; no flow control (outputs are strobes and levels).
interface clk_period_monitor_if #(
  parameter int CntW = 25
);
  logic            En;
  logic            ClkIn;
  logic            RisePulse;
  logic            FallPulse;
  logic            PeriodValid;
  logic [CntW-1:0] Period;
  logic [CntW-1:0] HighTime;
  logic            Stalled;

  modport master (
    output En, ClkIn,
    input  RisePulse, FallPulse, PeriodValid, Period, HighTime, Stalled
  );

  modport slave (
    input  En, ClkIn,
    output RisePulse, FallPulse, PeriodValid, Period, HighTime, Stalled
  );
endinterface

// File: rtl/clk_period_monitor.sv
// Synchronises a slow async clock, emits edge pulses, measures period/high time and flags stalls.
// Edge pulses and reports appear 3 Clk after ClkIn changes; no backpressure, results are strobes/levels.
module clk_period_monitor #(
  parameter int CntW       = 25,
  parameter int TimeoutVal = 1000000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  clk_period_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam logic [CntW-1:0] ONE          = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] TIMEOUT_LAST = CntW'(TimeoutVal - 1);

  state_t          state_q, state_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            s3_q, s3_d;
  logic            rise_pulse_q, rise_pulse_d;
  logic            fall_pulse_q, fall_pulse_d;
  logic            period_valid_q, period_valid_d;
  logic            stalled_q, stalled_d;
  logic [CntW-1:0] per_cnt_q, per_cnt_d;
  logic [CntW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CntW-1:0] period_q, period_d;
  logic [CntW-1:0] high_time_q, high_time_d;
  logic            rise;
  logic            fall;

  always_comb begin
    s1_d = mon.ClkIn;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    rise_pulse_d   = rise;
    fall_pulse_d   = fall;
    state_d        = state_q;
    per_cnt_d      = per_cnt_q;
    hi_cnt_d       = hi_cnt_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    stalled_d      = stalled_q;

    if (!mon.En) begin
      state_d   = IDLE;
      stalled_d = 1'b0;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      // On every accepted rise the high counter is seeded with 1: the rise cycle
      // itself already has s2 high and belongs to the new period's high time.
      case (state_q)
        IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          if (rise) begin
            state_d  = MEASURE;
            hi_cnt_d = ONE;
          end
        end
        MEASURE: begin
          per_cnt_d = per_cnt_q + ONE;
          hi_cnt_d  = hi_cnt_q + {{(CntW-1){1'b0}}, s2_q};
          if (rise) begin
            period_d       = per_cnt_q + ONE;
            high_time_d    = hi_cnt_q;
            period_valid_d = 1'b1;
            per_cnt_d      = '0;
            hi_cnt_d       = ONE;
          end else if (per_cnt_q == TIMEOUT_LAST) begin
            state_d   = STALL;
            stalled_d = 1'b1;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
          end
        end
        STALL: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          if (rise) begin
            state_d   = MEASURE;
            stalled_d = 1'b0;
            hi_cnt_d  = ONE;
          end
        end
        default: begin
          state_d   = IDLE;
          stalled_d = 1'b0;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      per_cnt_q      <= '0;
      hi_cnt_q       <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      per_cnt_q      <= per_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
    end
  end

  assign mon.RisePulse   = rise_pulse_q;
  assign mon.FallPulse   = fall_pulse_q;
  assign mon.PeriodValid = period_valid_q;
  assign mon.Period      = period_q;
  assign mon.HighTime    = high_time_q;
  assign mon.Stalled     = stalled_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: table of clock shapes plus hand sequences for stall, En and reset.
module tb_clk_period_monitor;
  localparam int CW = 16;
  localparam int TO = 20;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  clk_period_monitor_if #(.CntW(CW)) bus ();

  clk_period_monitor #(.CntW(CW), .TimeoutVal(TO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .mon (bus)
  );

  typedef struct {
    int cyc;
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
  } pv_t;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_high;
  } vec_t;

  int   cyc = 0;
  int   rise_q[$];
  int   fall_q[$];
  int   stall_on_q[$];
  int   stall_off_q[$];
  pv_t  pv_q[$];
  logic stall_prev = 1'b0;
  int   total = 0;
  int   passed = 0;
  vec_t vecs[5];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus.RisePulse === 1'b1) rise_q.push_back(cyc);
    if (bus.FallPulse === 1'b1) fall_q.push_back(cyc);
    if (bus.PeriodValid === 1'b1) pv_q.push_back('{cyc, bus.Period, bus.HighTime});
    if (bus.Stalled === 1'b1 && !stall_prev) stall_on_q.push_back(cyc);
    if (bus.Stalled === 1'b0 && stall_prev) stall_off_q.push_back(cyc);
    stall_prev = (bus.Stalled === 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    rise_q.delete();
    fall_q.delete();
    stall_on_q.delete();
    stall_off_q.delete();
    pv_q.delete();
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    bus.En = 1'b0;
    bus.ClkIn = 1'b0;
    step(3);
    Rst = 1'b1;
    clear_logs();
    step(1);
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      bus.ClkIn = 1'b1;
      step(hi);
      bus.ClkIn = 1'b0;
      step(lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4, 4, 4, 8, 4};
    vecs[1] = '{3, 5, 4, 8, 3};
    vecs[2] = '{1, 1, 4, 2, 1};
    vecs[3] = '{5, 1, 3, 6, 5};
    vecs[4] = '{2, 7, 3, 9, 2};

    Rst = 1'b0;
    bus.En = 1'b0;
    bus.ClkIn = 1'b0;
    #3;
    chk("reset_flags", {bus.RisePulse, bus.FallPulse, bus.PeriodValid, bus.Stalled}, 0);
    chk("reset_period", bus.Period, 0);
    chk("reset_high", bus.HighTime, 0);

    // Table of steady clock shapes
    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.En = 1'b1;
      run_wave(vecs[v].hi, vecs[v].lo, vecs[v].n);
      step(6);
      chk($sformatf("v%0d_rise_count", v), rise_q.size(), vecs[v].n);
      chk($sformatf("v%0d_pv_count", v), pv_q.size(), vecs[v].n - 1);
      for (int i = 1; i < rise_q.size(); i++)
        chk($sformatf("v%0d_rise_spacing%0d", v, i), rise_q[i] - rise_q[i-1], vecs[v].exp_period);
      for (int i = 0; i < pv_q.size() && i + 1 < rise_q.size(); i++) begin
        chk($sformatf("v%0d_pv%0d_cycle", v, i), pv_q[i].cyc, rise_q[i+1]);
        chk($sformatf("v%0d_pv%0d_period", v, i), pv_q[i].per, vecs[v].exp_period);
        chk($sformatf("v%0d_pv%0d_high", v, i), pv_q[i].hi, vecs[v].exp_high);
      end
      for (int i = 0; i < fall_q.size() && i < rise_q.size(); i++)
        chk($sformatf("v%0d_fall_offset%0d", v, i), fall_q[i] - rise_q[i], vecs[v].exp_high);
      chk($sformatf("v%0d_no_stall", v), stall_on_q.size(), 0);
    end

    // Stall after one rise, then recovery
    do_reset();
    bus.En = 1'b1;
    bus.ClkIn = 1'b1;
    step(4);
    bus.ClkIn = 1'b0;
    step(30);
    chk("stall_count", stall_on_q.size(), 1);
    if (stall_on_q.size() > 0 && rise_q.size() > 0)
      chk("stall_delay", stall_on_q[0] - rise_q[0], TO);
    chk("stall_level", bus.Stalled, 1);
    chk("stall_no_pv", pv_q.size(), 0);
    run_wave(4, 4, 2);
    step(6);
    chk("stall_rec_rises", rise_q.size(), 3);
    chk("stall_clear_count", stall_off_q.size(), 1);
    if (stall_off_q.size() > 0 && rise_q.size() > 1)
      chk("stall_clear_cycle", stall_off_q[0], rise_q[1]);
    chk("stall_rec_pv_count", pv_q.size(), 1);
    if (pv_q.size() > 0 && rise_q.size() > 2) begin
      chk("stall_rec_pv_cycle", pv_q[0].cyc, rise_q[2]);
      chk("stall_rec_period", pv_q[0].per, 8);
      chk("stall_rec_high", pv_q[0].hi, 4);
    end
    chk("stall_rec_level", bus.Stalled, 0);

    // Period equal to the timeout: rise beats the timeout
    do_reset();
    bus.En = 1'b1;
    run_wave(5, 15, 3);
    chk("coinc_pv_count", pv_q.size(), 2);
    for (int i = 0; i < pv_q.size(); i++) begin
      chk($sformatf("coinc_pv%0d_period", i), pv_q[i].per, TO);
      chk($sformatf("coinc_pv%0d_high", i), pv_q[i].hi, 5);
    end
    chk("coinc_no_stall", stall_on_q.size(), 0);
    chk("coinc_level", bus.Stalled, 0);

    // En dropped mid-period, then raised
    do_reset();
    bus.En = 1'b1;
    run_wave(4, 4, 3);
    chk("en_pre_pv_count", pv_q.size(), 2);
    bus.ClkIn = 1'b1;
    step(2);
    bus.En = 1'b0;
    pv_q.delete();
    step(2);
    bus.ClkIn = 1'b0;
    step(5);
    run_wave(5, 5, 2);
    chk("en_low_no_pv", pv_q.size(), 0);
    chk("en_low_period_hold", bus.Period, 8);
    chk("en_low_high_hold", bus.HighTime, 4);
    chk("en_low_stalled", bus.Stalled, 0);
    bus.En = 1'b1;
    rise_q.delete();
    pv_q.delete();
    run_wave(5, 5, 3);
    step(6);
    chk("en_up_rises", rise_q.size(), 3);
    chk("en_up_pv_count", pv_q.size(), 2);
    if (pv_q.size() > 0 && rise_q.size() > 1) begin
      chk("en_up_first_pv_cycle", pv_q[0].cyc, rise_q[1]);
      chk("en_up_period", pv_q[0].per, 10);
      chk("en_up_high", pv_q[0].hi, 5);
    end

    // Asynchronous reset mid-period
    do_reset();
    bus.En = 1'b1;
    run_wave(4, 4, 2);
    chk("arst_pre_period", bus.Period, 8);
    bus.ClkIn = 1'b1;
    step(2);
    #2;
    Rst = 1'b0;
    #1;
    chk("arst_period", bus.Period, 0);
    chk("arst_high", bus.HighTime, 0);
    chk("arst_flags", {bus.RisePulse, bus.FallPulse, bus.PeriodValid, bus.Stalled}, 0);
    step(2);
    bus.ClkIn = 1'b0;
    Rst = 1'b1;
    clear_logs();
    step(4);
    run_wave(4, 4, 2);
    step(6);
    chk("arst_post_rises", rise_q.size(), 2);
    chk("arst_post_pv_count", pv_q.size(), 1);
    if (pv_q.size() > 0 && rise_q.size() > 1) begin
      chk("arst_post_pv_cycle", pv_q[0].cyc, rise_q[1]);
      chk("arst_post_period", pv_q[0].per, 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
